// File: rtl/parity_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : parity_arbiter
// Brief    : Round-robin arbiter/sequencer sharing one parity engine among
//            NUM_REQ requesters. Define PARITY_ARB_TIMEOUT_EN for a watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module parity_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic                 result_odd,
  output logic                 result_err,
  output logic                 eng_start,
  output logic [7:0]           eng_data,
  input  logic                 eng_busy,
  input  logic                 eng_even,
  input  logic                 eng_odd
);

  localparam int                 c_PTR_W    = $clog2(NUM_REQ);
  localparam logic [c_PTR_W-1:0] c_LAST_IDX = c_PTR_W'(NUM_REQ - 1);
  localparam logic [c_PTR_W-1:0] c_ONE      = c_PTR_W'(1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1) begin : g_param_check
    $error("parity_arbiter: NUM_REQ must be 2..8 and TIMEOUT must be >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_RUN       = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [c_PTR_W-1:0]   r_last;
  logic [7:0]           r_eng_data;
  logic                 r_result_odd;
  logic                 r_result_err;

  logic [c_PTR_W-1:0]   w_cand;
  logic [c_PTR_W-1:0]   w_win_idx;
  logic                 w_win_valid;
  logic [NUM_REQ-1:0]   w_win_onehot;
  logic                 w_grant;
  logic                 w_tmo;

  // Search starts one past the last winner so every requester gets its turn.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_idx   = '0;
    w_cand      = (r_last == c_LAST_IDX) ? '0 : r_last + c_ONE;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_win_valid && req[w_cand]) begin
        w_win_valid = 1'b1;
        w_win_idx   = w_cand;
      end
      w_cand = (w_cand == c_LAST_IDX) ? '0 : w_cand + c_ONE;
    end
  end

  assign w_win_onehot = NUM_REQ'(1) << w_win_idx;
  // The engine has no reset; a job abandoned by our reset may still be running.
  assign w_grant      = (r_state == S_IDLE) && w_win_valid && !eng_busy;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (w_grant) w_state_nxt = S_START;
      S_START:     w_state_nxt = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (eng_busy)   w_state_nxt = S_RUN;
        else if (w_tmo) w_state_nxt = S_DONE;
      end
      S_RUN:       if (!eng_busy || w_tmo) w_state_nxt = S_DONE;
      S_DONE:      w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

`ifdef PARITY_ARB_TIMEOUT_EN
  localparam int c_CNT_W = $clog2(TIMEOUT + 1);

  logic [c_CNT_W-1:0] r_tmo_cnt;

  // Restarts from zero on every state change, so each wait gets its own budget.
  always_ff @(posedge clk) begin
    if (rst || (w_state_nxt != r_state)) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == S_WAIT_BUSY) || (r_state == S_RUN)) begin
      r_tmo_cnt <= r_tmo_cnt + c_CNT_W'(1);
    end
  end

  assign w_tmo = ((r_state == S_WAIT_BUSY) || (r_state == S_RUN)) &&
                 (r_tmo_cnt == c_CNT_W'(TIMEOUT - 1));
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_gnt        <= '0;
      r_last       <= c_LAST_IDX;
      r_eng_data   <= 8'h00;
      r_result_odd <= 1'b0;
      r_result_err <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_gnt      <= w_win_onehot;
            r_eng_data <= req_data[{w_win_idx, 3'b000} +: 8];
            r_last     <= w_win_idx;
          end
        end
        S_WAIT_BUSY: begin
          if (!eng_busy && w_tmo) begin
            r_result_odd <= 1'b0;
            r_result_err <= 1'b1;
          end
        end
        S_RUN: begin
          if (!eng_busy) begin
            r_result_odd <= eng_odd;
            r_result_err <= (eng_odd == eng_even);
          end else if (w_tmo) begin
            r_result_odd <= 1'b0;
            r_result_err <= 1'b1;
          end
        end
        S_DONE: begin
          r_gnt        <= '0;
          r_eng_data   <= 8'h00;
          r_result_odd <= 1'b0;
          r_result_err <= 1'b0;
        end
        default: begin
          r_gnt <= r_gnt;
        end
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign done       = (r_state == S_DONE) ? r_gnt : '0;
  assign eng_start  = (r_state == S_START);
  assign eng_data   = r_eng_data;
  assign result_odd = r_result_odd;
  assign result_err = r_result_err;

endmodule
`default_nettype wire

// File: tb/tb_parity_arbiter.sv
`default_nettype none
// tb_parity_arbiter: directed and randomized checks of parity_arbiter against a
// transaction-level reference model, driving a behavioural parity-engine stub.
module tb_parity_arbiter;
  localparam int N   = 4;
  localparam int TMO = 64;

  logic           clk      = 1'b0;
  logic           rst      = 1'b1;
  logic [N-1:0]   req      = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           result_odd;
  logic           result_err;
  logic           eng_start;
  logic [7:0]     eng_data;
  logic           eng_busy = 1'b0;
  logic           eng_even = 1'b0;
  logic           eng_odd  = 1'b0;

  always #5 clk = ~clk;

  parity_arbiter #(.NUM_REQ(N), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .done       (done),
    .result_odd (result_odd),
    .result_err (result_err),
    .eng_start  (eng_start),
    .eng_data   (eng_data),
    .eng_busy   (eng_busy),
    .eng_even   (eng_even),
    .eng_odd    (eng_odd)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase 0 idle, 1 transaction in flight, 2 cycle after done
  int           m_last  = N - 1;
  int           m_phase = 0;
  int           m_win   = 0;
  int           m_cyc   = 0;
  int           m_mode  = 0;
  logic [7:0]   m_data  = '0;
  logic [N-1:0] s_req   = '0;
  logic [8*N-1:0] s_data = '0;
  logic         s_busy  = 1'b0;
  logic         s_rst   = 1'b1;
  int           grant_log[$];
  int           done_log[$];
  logic [N-1:0] last_done = '0;
  logic         obs_odd = 1'b0;
  logic         obs_err = 1'b0;
  int           n_starts = 0;

  // Engine stub: mode 0 normal, 1 stuck busy, 2 faulty flags
  int           st_mode   = 0;
  int           st_delay  = 0;
  int           st_run    = 0;
  logic         st_active = 1'b0;
  logic [7:0]   st_data   = '0;

  logic [N-1:0] keep   = '0;
  bit           rnd_on = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      if (r[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_check();
    int w;
    int e_odd;
    int e_err;
    last_done = done;
    if (eng_start) n_starts++;
    if (done != '0) begin
      obs_odd = result_odd;
      obs_err = result_err;
    end
    if (s_rst) begin
      chk("rst_gnt", gnt, 0);
      chk("rst_done", done, 0);
      chk("rst_start", eng_start, 0);
      chk("rst_data", eng_data, 0);
      chk("rst_odd", result_odd, 0);
      chk("rst_err", result_err, 0);
      m_phase = 0;
      m_last  = N - 1;
      return;
    end
    case (m_phase)
      0: begin
        w = rr_pick(s_req, m_last);
        if (w >= 0 && !s_busy) begin
          chk("grant", gnt, 1 << w);
          chk("grant_data", eng_data, s_data[8*w +: 8]);
          chk("start_pulse", eng_start, 1);
          m_win   = w;
          m_last  = w;
          m_data  = s_data[8*w +: 8];
          m_mode  = st_mode;
          m_cyc   = 0;
          m_phase = 1;
          grant_log.push_back(w);
        end else begin
          chk("idle_gnt", gnt, 0);
          chk("idle_data", eng_data, 0);
          chk("idle_start", eng_start, 0);
        end
        chk("idle_done", done, 0);
      end
      1: begin
        m_cyc++;
        chk("hold_gnt", gnt, 1 << m_win);
        chk("hold_data", eng_data, m_data);
        chk("extra_start", eng_start, 0);
        if (done != '0) begin
          chk("done_bit", done, 1 << m_win);
          if (m_mode == 2) begin
            e_odd = 1;
            e_err = 1;
          end
`ifdef PARITY_ARB_TIMEOUT_EN
          else if (m_mode == 1) begin
            e_odd = 0;
            e_err = 1;
            chk("tmo_latency", m_cyc, 3 + TMO);
          end
`endif
          else begin
            e_odd = $countones(m_data) % 2;
            e_err = 0;
          end
          chk("result_odd", result_odd, e_odd);
          chk("result_err", result_err, e_err);
          done_log.push_back(m_win);
          m_phase = 2;
        end
      end
      default: begin
        chk("post_gnt", gnt, 0);
        chk("post_done", done, 0);
        chk("post_data", eng_data, 0);
        chk("post_start", eng_start, 0);
        m_phase = 0;
      end
    endcase
  endtask

  task automatic stub_update();
    if (eng_start) begin
      st_active = 1'b1;
      st_delay  = 2;
      st_data   = eng_data;
    end else if (st_active) begin
      if (st_delay > 0) begin
        st_delay--;
        if (st_delay == 0) begin
          eng_busy = 1'b1;
          st_run   = $urandom_range(1, 6);
        end
      end else if (st_mode != 1) begin
        st_run--;
        if (st_run <= 0) begin
          eng_busy  = 1'b0;
          st_active = 1'b0;
          if (st_mode == 2) begin
            eng_even = 1'b1;
            eng_odd  = 1'b1;
          end else begin
            eng_odd  = ^st_data;
            eng_even = ~^st_data;
          end
        end
      end
    end
  endtask

  task automatic drive_update();
    for (int i = 0; i < N; i++) begin
      if (last_done[i] && !keep[i]) req[i] = 1'b0;
      if (rnd_on) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          req_data[8*i +: 8] = 8'($urandom);
        end else if (req[i] && $urandom_range(0, 39) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    s_req  = req;
    s_data = req_data;
    s_busy = eng_busy;
    s_rst  = rst;
    @(negedge clk);
    model_check();
    stub_update();
    drive_update();
  endtask

  task automatic wait_done(input int i, input int budget, output bit got);
    got = 1'b0;
    for (int c = 0; c < budget && !got; c++) begin
      step();
      if (last_done[i]) got = 1'b1;
    end
    chk($sformatf("wait_done%0d", i), got, 1);
  endtask

  task automatic drain(input int budget);
    bit ok = 1'b0;
    for (int c = 0; c < budget && !ok; c++) begin
      step();
      ok = (req == '0) && (m_phase == 0) && !eng_busy;
    end
    chk("drain", ok, 1);
  endtask

  initial begin
    bit got;
    int base;
    int base2;

    repeat (3) step();
    rst = 1'b0;
    step();

    // Single requester, odd then even byte
    req_data[15:8] = 8'h07;
    req[1] = 1'b1;
    base = n_starts;
    wait_done(1, 50, got);
    chk("t1_gnt", grant_log[grant_log.size()-1], 1);
    chk("t1_odd", obs_odd, 1);
    chk("t1_err", obs_err, 0);
    chk("t1_starts", n_starts - base, 1);
    step();
    step();
    req_data[15:8] = 8'h03;
    req[1] = 1'b1;
    wait_done(1, 50, got);
    chk("t1b_odd", obs_odd, 0);
    chk("t1b_err", obs_err, 0);
    drain(50);

    // All four requesting from reset
    rst = 1'b1;
    req = '1;
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'($urandom);
    step();
    step();
    rst  = 1'b0;
    base = done_log.size();
    for (int c = 0; c < 200 && done_log.size() < base + 4; c++) step();
    chk("t2_count", done_log.size() - base, 4);
    for (int k = 0; k < 4 && base + k < done_log.size(); k++)
      chk($sformatf("t2_order%0d", k), done_log[base+k], k);
    drain(50);

    // Fairness between two continuous requesters
    keep = 4'b0101;
    req  = 4'b0101;
    base = grant_log.size();
    for (int c = 0; c < 300 && grant_log.size() < base + 6; c++) step();
    chk("t3_count", grant_log.size() - base, 6);
    for (int k = 0; k < 6 && base + k < grant_log.size(); k++)
      chk($sformatf("t3_order%0d", k), grant_log[base+k], (k % 2 == 0) ? 0 : 2);
    keep = '0;
    req  = '0;
    drain(100);

    // Engine reporting inconsistent flags
    st_mode = 2;
    req_data[31:24] = 8'($urandom);
    req[3] = 1'b1;
    wait_done(3, 50, got);
    chk("t4_err", obs_err, 1);
    st_mode = 0;
    drain(50);

    // Engine stuck busy
    st_mode = 1;
    req_data[23:16] = 8'h5A;
    req[2] = 1'b1;
    base = done_log.size();
`ifdef PARITY_ARB_TIMEOUT_EN
    wait_done(2, 3 * TMO, got);
    chk("t5_err", obs_err, 1);
    chk("t5_odd", obs_odd, 0);
    st_mode = 0;
    drain(50);
`else
    repeat (1000) step();
    chk("t5_no_done", done_log.size() - base, 0);
    st_mode = 0;
    wait_done(2, 50, got);
    chk("t5_err", obs_err, 0);
    chk("t5_odd", obs_odd, 0);
    drain(50);
`endif

    // Reset while the engine is running
    rst = 1'b1;
    step();
    rst     = 1'b0;
    st_mode = 1;
    keep    = 4'b0010;
    req     = 4'b0010;
    for (int c = 0; c < 20 && !(m_phase == 1 && m_cyc >= 4); c++) step();
    chk("t6_in_run", (m_phase == 1 && m_cyc >= 4), 1);
    req = 4'b0111;
    rst = 1'b1;
    step();
    rst   = 1'b0;
    base  = n_starts;
    base2 = grant_log.size();
    repeat (10) step();
    chk("t6_no_start", n_starts - base, 0);
    chk("t6_no_grant", grant_log.size() - base2, 0);
    st_mode = 0;
    for (int c = 0; c < 40 && grant_log.size() == base2; c++) step();
    chk("t6_next_grant", (grant_log.size() > base2) ? grant_log[base2] : -1, 0);
    keep = '0;
    req  = '0;
    drain(50);

    // Randomized traffic
    st_mode = 0;
    keep    = N'($urandom);
    base    = done_log.size();
    rnd_on  = 1'b1;
    repeat (600) step();
    rnd_on = 1'b0;
    keep   = '0;
    drain(500);
    chk("rnd_activity", done_log.size() > base + 10, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/parity_arbiter.md
# parity_arbiter

Round-robin arbiter and sequencer that shares one `parity` engine among `NUM_REQ` requesters. It grants one requester at a time, latches that requester's byte, pulses the engine's `start`, and tracks the engine's `busy` through a full computation. It then samples `even_parity`/`odd_parity` and returns a one-cycle `done` pulse with the result to the granted requester. It sits between client logic and the single `parity` instance, owning all of that instance's inputs.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `TIMEOUT`, 64: watchdog limit in cycles for any engine wait. Used only with `PARITY_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  NUM_REQ  per-requester request level. Hold high until `done`.
- `req_data`  in  8*NUM_REQ  byte for requester i at bits [8i+7:8i].
- `gnt`  out  NUM_REQ  one-hot grant, held for the whole transaction.
- `done`  out  NUM_REQ  one-cycle completion pulse on the granted bit.
- `result_odd`  out  1  1 = odd number of ones. Valid only while any `done` bit is high.
- `result_err`  out  1  engine fault flag. Valid only while any `done` bit is high.
- `eng_start`  out  1  to `parity.start`.
- `eng_data`  out  8  to `parity.data_in`.
- `eng_busy`  in  1  from `parity.busy`.
- `eng_even`  in  1  from `parity.even_parity`.
- `eng_odd`  in  1  from `parity.odd_parity`.

## Operation
- FSM states: IDLE, START, WAIT_BUSY, RUN, DONE.
- **IDLE**
  - Requires `|req` and `eng_busy==0`.
  - Selects the winner by round-robin, searching from `last+1` modulo NUM_REQ.
  - Registers `gnt`, latches `req_data` of the winner into `eng_data`, updates `last`, and goes to START.
  - While `eng_busy==1`, no grant is issued (engine still finishing an abandoned job).
- **START**: `eng_start=1` for exactly this cycle; go to WAIT_BUSY.
- **WAIT_BUSY**: wait for `eng_busy==1`, then go to RUN.
- **RUN**: on the edge where `eng_busy==0` is sampled:
  - register `result_odd <= eng_odd`;
  - register `result_err <= (eng_odd == eng_even)`;
  - go to DONE.
- **DONE**
  - `done = gnt` for one cycle.
  - The next edge clears `gnt`, `result_odd` and `result_err`, and returns to IDLE.
- `eng_data` is held constant from grant through DONE. It is 0 in IDLE with no grant.
- Requester rules:
  - A requester deasserting `req` mid-transaction does not abort; `done` still pulses.
  - A requester still asserting `req` in the cycle after `done` is treated as a new request, ranked after the others.
- Simultaneous requests in IDLE resolve strictly by the round-robin pointer. Lower index never wins by default except via the pointer.
- Pointer `last`:
  - width `$clog2(NUM_REQ)`;
  - wraps from NUM_REQ-1 to 0;
  - reset value NUM_REQ-1, so requester 0 wins first after reset.

## Timing
- Reset values:
  - `gnt`, `done`, `result_odd`, `result_err`, `eng_start` = 0;
  - `eng_data` = 8'h00;
  - state = IDLE.
- `eng_start` and `done` are decoded from the registered state, with no combinational path from `req`.
- Cycle sequence (edge E0 = IDLE edge that samples `req` high):
  - after E0: `gnt` high, START;
  - after E1: WAIT_BUSY;
  - engine raises `busy` about 2 cycles after `start`.
- Arbiter overhead:
  - 3 cycles fixed: grant, start, done;
  - plus engine run time;
  - plus 1 cycle after `eng_busy` falls.
- Back-to-back service: the next grant can occur on the edge immediately following DONE. Minimum gap between `done` pulses equals one full transaction.
- Reset mid-transaction:
  - arbiter returns to IDLE and the job is dropped with no `done`;
  - the engine has no reset, so the IDLE `eng_busy` interlock prevents a new start until the engine finishes.

## Configuration
- `PARITY_ARB_TIMEOUT_EN` defined:
  - a cycle counter runs in WAIT_BUSY and RUN and clears on state entry;
  - when the counter reaches TIMEOUT, go to DONE with `result_err=1` and `result_odd=0`.
- Not defined: no counter; WAIT_BUSY and RUN wait indefinitely; TIMEOUT is ignored.

## Test plan
- Single requester, NUM_REQ=4:
  - `req[1]` with 0x07 -> `gnt=4'b0010`, one `eng_start` pulse, `done[1]` with `result_odd=1`, `result_err=0`;
  - repeat with 0x03 -> `result_odd=0`.
- All four requesting from reset, each holding until its own `done`: done order is 0,1,2,3, each exactly once, never two `gnt` bits high.
- Fairness: `req[0]` and `req[2]` held continuously -> grants alternate 0,2,0,2 across 6 transactions.
- Engine stub holds `eng_busy=1` forever:
  - macro defined, TIMEOUT=64 -> `done` with `result_err=1` 64 cycles after WAIT_BUSY/RUN entry;
  - macro undefined -> no `done` within 1000 cycles.
- Engine stub returns `eng_even=eng_odd=1` -> `result_err=1` at `done`.
- Assert `rst` in RUN while the engine is busy:
  - all outputs go to 0;
  - with `req` still high, no `eng_start` until `eng_busy` has fallen;
  - the next grant goes to requester 0.
